// File: rtl/act_cache_pkg.sv
// act_cache_pkg: shared types, constants and helpers for the activation way-select pipeline.
//   ACT_MAX_WAYS / ACT_IDX_W : upper bound on ways handled by the helper functions
//   ACT_DEFAULT              : all-ones default activation (slice to WORD_SIZE)
//   sel_entry_t              : queue entry {data, hit, way} for the default 16-bit / 5-way build
//   onehot_lowest_idx()      : index of the lowest set bit
//   popcount_gt1()           : more than one bit set
package act_cache_pkg;

    localparam int ACT_MAX_WAYS = 64;
    localparam int ACT_IDX_W = 6;
    localparam int ACT_MAX_W = 256;
    localparam int ACT_DEF_WORD_SIZE = 16;
    localparam int ACT_DEF_WAY_W = 3;

    localparam logic [ACT_MAX_W-1:0] ACT_DEFAULT = '1;

    typedef struct packed {
        logic [ACT_DEF_WORD_SIZE-1:0] data;
        logic hit;
        logic [ACT_DEF_WAY_W-1:0] way;
    } sel_entry_t;

    function automatic logic [ACT_IDX_W-1:0] onehot_lowest_idx(input logic [ACT_MAX_WAYS-1:0] v);
        logic [ACT_IDX_W-1:0] idx;
        idx = '0;
        for (int i = ACT_MAX_WAYS - 1; i >= 0; i--)
            if (v[i]) idx = ACT_IDX_W'(i);
        return idx;
    endfunction

    // v & (v-1) clears the lowest set bit; anything left means a second bit was set
    function automatic logic popcount_gt1(input logic [ACT_MAX_WAYS-1:0] v);
        return |(v & (v - ACT_MAX_WAYS'(1)));
    endfunction

endpackage

// File: rtl/act_skid_fifo2.sv
// act_skid_fifo2: 2-entry registered FIFO with valid/ready on both sides.
//   in_valid/in_ready/din    : write side; in_ready depends only on registered occupancy
//   out_valid/out_ready/dout : read side; dout is the head register, held when empty
module act_skid_fifo2
    import act_cache_pkg::*;
#(
    parameter type T = sel_entry_t,
    parameter T RST_VAL = T'('0)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     din,
    output logic out_valid,
    input  logic out_ready,
    output T     dout
);

    logic [1:0] count;
    T head;
    T tail;
    logic push;
    logic pop;

    assign in_ready = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign push = in_valid && in_ready;
    assign pop = out_ready && out_valid;
    assign dout = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 2'd0;
            head <= RST_VAL;
            tail <= RST_VAL;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            // head loads new data when the queue is (or is becoming) empty, else advances from tail
            if (push && (count == 2'd0 || (count == 2'd1 && pop)))
                head <= din;
            else if (pop && count == 2'd2)
                head <= tail;
            if (push && count == 2'd1 && !pop)
                tail <= din;
        end
    end

endmodule

// File: rtl/activation_way_select_pipe.sv
// activation_way_select_pipe: selects the hitting way's activation and queues it with hit statistics.
//   in_valid/in_ready         : lookup handshake (way_data, way_hit, enable sampled on accept)
//   out_valid/out_ready       : result handshake for activation_out, out_hit, out_way
//   multi_hit_err             : sticky flag for accepted lookups with more than one hit bit
//   hit_count/miss_count      : saturating statistics, cleared by clear_stats
module activation_way_select_pipe
    import act_cache_pkg::*;
#(
    parameter int NWAYS = 5,
    parameter int WORD_SIZE = 16,
    parameter int CNT_W = 16,
    localparam int WAY_W = NWAYS > 1 ? $clog2(NWAYS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NWAYS*WORD_SIZE-1:0] way_data,
    input  logic [NWAYS-1:0]           way_hit,
    input  logic                       enable,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_SIZE-1:0]       activation_out,
    output logic                       out_hit,
    output logic [WAY_W-1:0]           out_way,
    output logic                       multi_hit_err,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count,
    input  logic                       clear_stats
);

    typedef struct packed {
        logic [WORD_SIZE-1:0] data;
        logic hit;
        logic [WAY_W-1:0] way;
    } entry_t;

    localparam entry_t ENTRY_RST = '{data: ACT_DEFAULT[WORD_SIZE-1:0], hit: 1'b0, way: '0};

    logic [ACT_MAX_WAYS-1:0] hit_ext;
    logic [ACT_IDX_W-1:0] idx;
    logic hit;
    logic accept;
    entry_t sel;
    entry_t head;

    assign hit_ext = ACT_MAX_WAYS'(way_hit);
    assign idx = onehot_lowest_idx(hit_ext);
    assign hit = |way_hit;
    assign accept = in_valid && in_ready;

    always_comb begin
        sel = ENTRY_RST;
        if (enable && hit) begin
            sel.data = way_data[int'(idx)*WORD_SIZE +: WORD_SIZE];
            sel.hit = 1'b1;
            sel.way = WAY_W'(idx);
        end
    end

    act_skid_fifo2 #(
        .T(entry_t),
        .RST_VAL(ENTRY_RST)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .din(sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout(head)
    );

    assign activation_out = head.data;
    assign out_hit = head.hit;
    assign out_way = head.way;

    // clear_stats wins over a same-cycle event, so that event is dropped
    always_ff @(posedge clk) begin
        if (rst || clear_stats) begin
            hit_count <= '0;
            miss_count <= '0;
            multi_hit_err <= 1'b0;
        end else if (accept) begin
            if (hit && hit_count != '1)
                hit_count <= hit_count + CNT_W'(1);
            if (!hit && miss_count != '1)
                miss_count <= miss_count + CNT_W'(1);
            if (popcount_gt1(hit_ext))
                multi_hit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_activation_way_select_pipe.sv
// tb_activation_way_select_pipe: directed self-checking bench for activation_way_select_pipe.
module tb_activation_way_select_pipe;

    localparam int NWAYS = 5;
    localparam int WORD_SIZE = 16;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic [NWAYS*WORD_SIZE-1:0] way_data;
    logic [NWAYS-1:0] way_hit;
    logic enable;
    logic out_valid;
    logic out_ready;
    logic [WORD_SIZE-1:0] activation_out;
    logic out_hit;
    logic [2:0] out_way;
    logic multi_hit_err;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
    logic clear_stats;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    activation_way_select_pipe #(
        .NWAYS(NWAYS),
        .WORD_SIZE(WORD_SIZE),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .way_data(way_data),
        .way_hit(way_hit),
        .enable(enable),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .activation_out(activation_out),
        .out_hit(out_hit),
        .out_way(out_way),
        .multi_hit_err(multi_hit_err),
        .hit_count(hit_count),
        .miss_count(miss_count),
        .clear_stats(clear_stats)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [NWAYS-1:0] h, input logic en);
        in_valid = 1'b1;
        way_hit = h;
        enable = en;
    endtask

    task automatic expect_head(input string tag, input logic [15:0] d, input logic h, input logic [2:0] w);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(activation_out), 32'(d));
        check({tag, "_hit"}, 32'(out_hit), 32'(h));
        check({tag, "_way"}, 32'(out_way), 32'(w));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        way_hit = '0;
        enable = 1'b1;
        out_ready = 1'b1;
        clear_stats = 1'b0;
        way_data = {16'h5555, 16'h1234, 16'hAAAA, 16'h1111, 16'h1000};
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_act", 32'(activation_out), 32'hFFFF);
        check("rst_hit", 32'(out_hit), 32'd0);
        check("rst_way", 32'(out_way), 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_mhe", 32'(multi_hit_err), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        lookup(5'b01000, 1'b1);
        tick();
        expect_head("single", 16'h1234, 1'b1, 3'd3);
        check("single_hits", 32'(hit_count), 32'd1);

        lookup(5'b00000, 1'b1);
        tick();
        expect_head("miss", 16'hFFFF, 1'b0, 3'd0);
        check("miss_miss", 32'(miss_count), 32'd1);
        check("miss_hits", 32'(hit_count), 32'd1);

        lookup(5'b00010, 1'b0);
        tick();
        expect_head("disabled", 16'hFFFF, 1'b0, 3'd0);
        check("disabled_hits", 32'(hit_count), 32'd2);

        lookup(5'b10100, 1'b1);
        tick();
        expect_head("multi", 16'hAAAA, 1'b1, 3'd2);
        check("multi_mhe", 32'(multi_hit_err), 32'd1);
        check("multi_hits", 32'(hit_count), 32'd3);

        in_valid = 1'b0;
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("mhe_sticky", 32'(multi_hit_err), 32'd1);

        lookup(5'b00001, 1'b1);
        tick();
        tick();
        expect_head("sat", 16'h1000, 1'b1, 3'd0);
        check("sat_hits", 32'(hit_count), 32'd3);
        check("sat_miss", 32'(miss_count), 32'd1);

        in_valid = 1'b0;
        out_ready = 1'b0;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("clr_hits", 32'(hit_count), 32'd0);
        check("clr_miss", 32'(miss_count), 32'd0);
        check("clr_mhe", 32'(multi_hit_err), 32'd0);
        expect_head("clr_queue", 16'h1000, 1'b1, 3'd0);
        out_ready = 1'b1;
        tick();
        check("clr_drain", 32'(out_valid), 32'd0);

        lookup(5'b01000, 1'b1);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        in_valid = 1'b0;
        check("clr_hit_same", 32'(hit_count), 32'd0);
        expect_head("clr_push", 16'h1234, 1'b1, 3'd3);
        tick();

        out_ready = 1'b0;
        lookup(5'b00001, 1'b1);
        tick();
        check("bp1_in_ready", 32'(in_ready), 32'd1);
        expect_head("bp1", 16'h1000, 1'b1, 3'd0);
        lookup(5'b00010, 1'b1);
        tick();
        check("bp2_in_ready", 32'(in_ready), 32'd0);
        check("bp2_hits", 32'(hit_count), 32'd2);
        lookup(5'b10000, 1'b1);
        tick();
        check("bp3_in_ready", 32'(in_ready), 32'd0);
        check("bp3_hits", 32'(hit_count), 32'd2);
        expect_head("bp3_stable", 16'h1000, 1'b1, 3'd0);
        tick();
        expect_head("bp4_stable", 16'h1000, 1'b1, 3'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        expect_head("bp_second", 16'h1111, 1'b1, 3'd1);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        lookup(5'b00010, 1'b1);
        tick();
        expect_head("tp1", 16'h1111, 1'b1, 3'd1);
        lookup(5'b10000, 1'b1);
        tick();
        expect_head("tp2", 16'h5555, 1'b1, 3'd4);
        check("tp2_in_ready", 32'(in_ready), 32'd1);
        lookup(5'b00001, 1'b1);
        tick();
        expect_head("tp3", 16'h1000, 1'b1, 3'd0);
        check("tp3_in_ready", 32'(in_ready), 32'd1);
        check("tp_hits", 32'(hit_count), 32'd3);
        check("tp_miss", 32'(miss_count), 32'd0);

        out_ready = 1'b0;
        lookup(5'b01000, 1'b1);
        tick();
        tick();
        check("mid_full", 32'(in_ready), 32'd0);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        rst = 1'b1;
        lookup(5'b00100, 1'b1);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_act", 32'(activation_out), 32'hFFFF);
        check("mid_rst_hits", 32'(hit_count), 32'd0);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_hits", 32'(hit_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/activation_way_select_pipe.md
Name: activation_way_select_pipe

Overview:
- Parametrised, pipelined successor to the cache's combinational way-output mux. It takes NWAYS way data words plus the one-hot hit vector from tag compare.
- It selects the hitting way's activation and resolves misses and multi-hits. Results are buffered in a 2-entry output queue with valid/ready handshake.
- Sits between the activation cache data arrays and the MAC/neuron datapath. It also keeps saturating hit/miss statistics for the layer controller.

Parameters:
- NWAYS, 5, number of cache ways (>=1).
- WORD_SIZE, 16, activation width in bits.
- CNT_W, 16, width of hit/miss statistics counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  lookup result present this cycle.
- in_ready  out  1  block can accept a lookup result.
- way_data  in  NWAYS*WORD_SIZE  flattened way outputs; way i at bits [i*WORD_SIZE +: WORD_SIZE].
- way_hit  in  NWAYS  one-hot hit vector from tag compare.
- enable  in  1  output enable; 0 forces default activation for accepted lookups.
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer accepts head.
- activation_out  out  WORD_SIZE  head activation.
- out_hit  out  1  head was a hit.
- out_way  out  $clog2(NWAYS) (min 1)  head hitting way index; 0 on miss.
- multi_hit_err  out  1  sticky: at least one accepted lookup had >1 bit set in way_hit.
- hit_count  out  CNT_W  saturating count of accepted hits.
- miss_count  out  CNT_W  saturating count of accepted misses.
- clear_stats  in  1  synchronous clear of counters and multi_hit_err.

Behaviour:
- Reset (rst=1 on a clock edge):
  - Queue is emptied; out_valid=0; in_ready=1.
  - activation_out='1, out_hit=0, out_way=0.
  - multi_hit_err=0; both counters=0.
  - An in-flight lookup is discarded and not counted.
- Accept rule: accept = in_valid && in_ready. in_ready = (occupancy < 2), from registered state only; no combinational path from out_ready.
- Selection, applied at accept:
  - Lowest-index set bit of way_hit gives idx; hit = |way_hit.
  - Entry value is {data = way i of idx, hit=1, way=idx} when enable && hit.
  - It is {data='1, hit=0, way=0} when !hit or !enable.
  - enable=0 with a hit still counts as a hit.
- Multi-hit: popcount(way_hit)>1 on accept sets multi_hit_err. The lowest-index way is still selected.
- Queue: 2-entry FIFO; head drives the out_* ports directly from registers.
  - Latency: accepted in cycle N, visible with out_valid=1 in cycle N+1.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Full: in_ready=0; in_valid is ignored and not counted.
  - Empty: out_valid=0; out_* hold the last popped values (don't-care for checking); out_ready is ignored.
  - Head is stable while out_valid && !out_ready.
- Throughput: 1 lookup/cycle sustained while out_ready=1.
- Counters:
  - On accept, increment hit_count if hit, else miss_count.
  - Both saturate at 2^CNT_W-1; no wrap.
  - clear_stats has priority over an increment in the same cycle: the result is 0, and that cycle's event is lost.
  - clear_stats does not affect the queue.
- NWAYS=1: out_way width is 1 and is always 0.

Decomposition:
- Package act_cache_pkg:
  - ACT_DEFAULT function/constant (all ones, WORD_SIZE).
  - sel_entry_t struct: data, hit, way.
  - Function onehot_lowest_idx.
  - Function popcount_gt1.
- Sub-module act_skid_fifo2 (2-entry registered FIFO of sel_entry_t, valid/ready both sides). Top holds selection, statistics and error logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, in_ready=1, activation_out=16'hFFFF, counters 0, multi_hit_err=0.
- Single hit: way 3 data=16'h1234, way_hit=5'b01000, enable=1, out_ready=1 -> next cycle out_valid=1, activation_out=16'h1234, out_hit=1, out_way=3; hit_count=1.
- Miss and disable:
  - way_hit=0 -> activation_out=16'hFFFF, out_hit=0, miss_count=1.
  - Then way_hit=5'b00010 with enable=0 -> 16'hFFFF, hit_count increments.
- Multi-hit: way_hit=5'b10100, way2=16'hAAAA, way4=16'h5555 -> activation_out=16'hAAAA, out_way=2, multi_hit_err=1 held until clear_stats.
- Backpressure: out_ready=0, in_valid=1 with 3 distinct lookups:
  - in_ready drops after 2 accepts; the third is not counted.
  - Raise out_ready -> entries emerge in order, head stable while stalled.
- Saturation and clear:
  - CNT_W=2, 5 hits -> hit_count=3.
  - clear_stats together with an accepted hit -> hit_count=0.
  - rst asserted mid-stream with 2 queued entries -> out_valid=0 next cycle.
